// File: rtl/clock_pkg.sv
// Shared definitions for the hh:mm:ss timekeeper: mode encoding, BCD limits,
// field increment helpers and the prescaler width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_HR  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  localparam int TEN_MAX  = 5;  // tens digit of seconds/minutes
  localparam int ONE_MAX  = 9;
  localparam int HR10_MAX = 2;  // hours roll at 23
  localparam int HR1_MAX  = 3;

  typedef struct packed {
    logic       wrap;
    logic [2:0] t;
    logic [3:0] o;
  } inc60_t;

  typedef struct packed {
    logic       wrap;
    logic [1:0] t;
    logic [3:0] o;
  } inc24_t;

  function automatic int div_w(int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic inc60_t inc60(logic [2:0] t, logic [3:0] o);
    inc60_t r;
    r = '0;
    if (o != 4'(ONE_MAX)) begin
      r.t = t;
      r.o = o + 4'd1;
    end else if (t != 3'(TEN_MAX)) begin
      r.t = t + 3'd1;
    end else begin
      r.wrap = 1'b1;
    end
    return r;
  endfunction

  function automatic inc24_t inc24(logic [1:0] t, logic [3:0] o);
    inc24_t r;
    r = '0;
    if (t == 2'(HR10_MAX) && o == 4'(HR1_MAX)) begin
      r.wrap = 1'b1;
    end else if (o == 4'(ONE_MAX)) begin
      r.t = t + 2'd1;
    end else begin
      r.t = t;
      r.o = o + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for one active-low key plus a one-cycle press pulse
// on each synchronised 1->0 transition.
module key_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic       s1, s2, prev;
  logic [1:0] vld_pipe;

  // prev only learns from real samples, so a key already low when reset
  // releases never produces a press until it is seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= key;
      s2       <= s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
      prev     <= vld_pipe[1] & s2;
    end
  end

  assign press = vld_pipe[1] & prev & ~s2;

endmodule

// File: rtl/clock_hms.sv
// BCD hh:mm:ss timekeeper with prescaler, set/hold modes, hh:mm alarm,
// day-wrap carry pulse and optional 12-hour display mapping.
module clock_hms
  import clock_pkg::*;
#(
  parameter int DIV = 50_000_000,
  parameter int H12 = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] sec1,
  output logic [2:0] sec10,
  output logic [3:0] min1,
  output logic [2:0] min10,
  output logic [3:0] hr1,
  output logic [1:0] hr10,
  output logic       PM,
  output logic       CA,
  output logic       ALARM
);

  localparam int PW = div_w(DIV);

  logic [3:0] sw_m, sw_s;
  logic       sw_unused;
  mode_e      mode;
  logic       tgt_alm, alm_en;
  logic [1:0] press;
  logic       inc_p, clr_p;

  logic [PW-1:0] pcnt;
  logic          run, tick;

  logic [2:0] s10, m10, am10, ns10, nm10, nam10;
  logic [3:0] s1, m1, am1, h1, ah1, ns1, nm1, nam1, nh1, nah1;
  logic [1:0] h10, ah10, nh10, nah10;
  logic       day_wrap, min_chg, alm_hit;
  inc60_t     si, mi, ami;
  inc24_t     hi, ahi;

  assign sw_unused = ^SW[6:1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= {SW[9:7], SW[0]};
      sw_s <= sw_m;
    end
  end

  assign mode    = mode_e'(sw_s[3:2]);
  assign tgt_alm = sw_s[1];
  assign alm_en  = sw_s[0];

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_sync_edge u_ks (
      .clk   (CLK),
      .rst   (RST),
      .key   (KEY[i]),
      .press (press[i])
    );
  end

  assign inc_p = press[0];
  assign clr_p = press[1];

  assign run  = (mode == MODE_RUN);
  assign tick = run && (pcnt == PW'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST || !run) pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else             pcnt <= pcnt + 1'b1;
  end

  assign si  = inc60(s10, s1);
  assign mi  = inc60(m10, m1);
  assign hi  = inc24(h10, h1);
  assign ami = inc60(am10, am1);
  assign ahi = inc24(ah10, ah1);

  always_comb begin
    {ns10, ns1}   = {s10, s1};
    {nm10, nm1}   = {m10, m1};
    {nh10, nh1}   = {h10, h1};
    {nam10, nam1} = {am10, am1};
    {nah10, nah1} = {ah10, ah1};
    day_wrap      = 1'b0;
    case (mode)
      MODE_RUN: begin
        if (tick) begin
          {ns10, ns1} = {si.t, si.o};
          if (si.wrap) begin
            {nm10, nm1} = {mi.t, mi.o};
            if (mi.wrap) begin
              {nh10, nh1} = {hi.t, hi.o};
              day_wrap    = hi.wrap;
            end
          end
        end
      end
      MODE_SET_MIN, MODE_SET_HR: begin
        // Set-mode increments wrap inside their own field only.
        if (!tgt_alm && (inc_p || clr_p)) {ns10, ns1} = '0;
        if (inc_p) begin
          if (mode == MODE_SET_MIN) begin
            if (tgt_alm) {nam10, nam1} = {ami.t, ami.o};
            else         {nm10, nm1}   = {mi.t, mi.o};
          end else begin
            if (tgt_alm) {nah10, nah1} = {ahi.t, ahi.o};
            else         {nh10, nh1}   = {hi.t, hi.o};
          end
        end
      end
      default: ;
    endcase
  end

  assign min_chg = ({nm10, nm1} != {m10, m1});
  assign alm_hit = tick && alm_en && ({ns10, ns1} == '0) &&
                   ({nh10, nh1, nm10, nm1} == {ah10, ah1, am10, am1});

  always_ff @(posedge CLK) begin
    if (RST) begin
      {s10, s1, m10, m1, h10, h1} <= '0;
      {am10, am1, ah10, ah1}      <= '0;
      CA                          <= 1'b0;
      ALARM                       <= 1'b0;
    end else begin
      {s10, s1, m10, m1, h10, h1} <= {ns10, ns1, nm10, nm1, nh10, nh1};
      {am10, am1, ah10, ah1}      <= {nam10, nam1, nah10, nah1};
      CA                          <= day_wrap;
      // Dismiss wins over a coincident hit; hit is checked before minute change
      // because the hitting tick is itself a minute change.
      if (clr_p || !alm_en) ALARM <= 1'b0;
      else if (alm_hit)     ALARM <= 1'b1;
      else if (min_chg)     ALARM <= 1'b0;
    end
  end

  logic       show_alm;
  logic [1:0] dh10;
  logic [3:0] dh1;
  logic [4:0] hbin, hdisp;

  assign show_alm = tgt_alm && (mode == MODE_SET_MIN || mode == MODE_SET_HR);
  assign sec10    = s10;
  assign sec1     = s1;
  assign min10    = show_alm ? am10 : m10;
  assign min1     = show_alm ? am1  : m1;
  assign dh10     = show_alm ? ah10 : h10;
  assign dh1      = show_alm ? ah1  : h1;
  assign hbin     = {3'b000, dh10} * 5'd10 + {1'b0, dh1};

  always_comb begin
    hdisp = hbin;
    PM    = 1'b0;
    hr10  = dh10;
    hr1   = dh1;
    if (H12 != 0) begin
      PM = (hbin >= 5'd12);
      if (hbin == 5'd0)      hdisp = 5'd12;
      else if (hbin > 5'd12) hdisp = hbin - 5'd12;
      if (hdisp >= 5'd10) begin
        hr10 = 2'd1;
        hr1  = 4'(hdisp - 5'd10);
      end else begin
        hr10 = 2'd0;
        hr1  = hdisp[3:0];
      end
    end
  end

endmodule

// File: tb/tb_clock_hms.sv
// Directed bench for clock_hms: a 24-hour and a 12-hour instance share stimulus.
module tb_clock_hms;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] SW  = '0;
  logic [1:0] KEY = 2'b11;

  logic [3:0] sec1, min1, hr1;
  logic [2:0] sec10, min10;
  logic [1:0] hr10;
  logic       PM, CA, ALARM;

  logic [3:0] d_sec1, d_min1, d_hr1;
  logic [2:0] d_sec10, d_min10;
  logic [1:0] d_hr10;
  logic       d_PM, d_CA, d_ALARM;

  int n_chk = 0;
  int n_fail = 0;
  int ca_cnt = 0;

  clock_hms #(.DIV(4), .H12(0)) u_dut (
    .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY),
    .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
    .hr1(hr1), .hr10(hr10), .PM(PM), .CA(CA), .ALARM(ALARM)
  );

  clock_hms #(.DIV(4), .H12(1)) u_d12 (
    .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY),
    .sec1(d_sec1), .sec10(d_sec10), .min1(d_min1), .min10(d_min10),
    .hr1(d_hr1), .hr10(d_hr10), .PM(d_PM), .CA(d_CA), .ALARM(d_ALARM)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (CA) ca_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int t24();
    return (int'(hr10) * 10 + int'(hr1)) * 10000 +
           (int'(min10) * 10 + int'(min1)) * 100 + int'(sec10) * 10 + int'(sec1);
  endfunction

  function automatic int h12();
    return int'(d_hr10) * 10 + int'(d_hr1);
  endfunction

  function automatic int d12_ms();
    return (int'(d_min10) * 10 + int'(d_min1)) * 100 + int'(d_sec10) * 10 + int'(d_sec1);
  endfunction

  // advance n rising edges, then sit 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m, input logic tgt, input logic en);
    SW = {m, tgt, 6'b0, en};
    step(3);
  endtask

  task automatic press(input int k);
    KEY[k] = 1'b0;
    step(3);
    KEY[k] = 1'b1;
    step(3);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_time"}, t24(), 0);
    chk({tag, "_ca"}, int'(CA), 0);
    chk({tag, "_alarm"}, int'(ALARM), 0);
    chk({tag, "_pm24"}, int'(PM), 0);
    chk({tag, "_h12"}, h12(), 12);
    chk({tag, "_pm12"}, int'(d_PM), 0);
    chk({tag, "_d12ms"}, d12_ms(), 0);
    chk({tag, "_d12flags"}, int'({d_CA, d_ALARM}), 0);
  endtask

  initial begin
    int base, prev_t, early, hi;
    bit found;

    // reset state
    step(1);
    chk_reset("rst");
    RST = 1'b0;

    // free run: exact tick period, 240 edges -> 00:01:00
    step(239);
    chk("run_59s", t24(), 59);
    step(1);
    chk("run_1m", t24(), 100);
    chk("run_ca", ca_cnt, 0);

    // restart and run to 00:00:30
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(120);
    chk("pre_set", t24(), 30);

    // SET_MIN: frozen, key latency, 3 presses -> 00:03:00
    set_mode(2'b01, 1'b0, 1'b0);
    step(20);
    chk("set_frozen", t24(), 30);
    KEY[0] = 1'b0;
    step(2);
    chk("key_lat2", t24(), 30);
    step(1);
    chk("key_lat3", t24(), 100);
    KEY[0] = 1'b1;
    step(3);
    press(0);
    press(0);
    chk("set_min3", t24(), 300);
    step(20);
    chk("set_noadv", t24(), 300);

    // SET_HR: 23 presses with 12-hour mapping checks on the way
    set_mode(2'b10, 1'b0, 1'b0);
    for (int i = 1; i <= 23; i++) begin
      press(0);
      if (i == 12) begin
        chk("h12_12", h12(), 12);
        chk("h12_12pm", int'(d_PM), 1);
      end
      if (i == 13) begin
        chk("h12_13", h12(), 1);
        chk("h12_13pm", int'(d_PM), 1);
        chk("h24_13", t24(), 130300);
        chk("h24_13pm", int'(PM), 0);
      end
    end
    chk("set_hr23", t24(), 230300);
    chk("h12_23", h12(), 11);
    chk("set_ca", ca_cnt, 0);

    // day wrap from 23:59:00
    set_mode(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) press(0);
    chk("set_2359", t24(), 235900);
    set_mode(2'b00, 1'b0, 1'b0);
    base = ca_cnt;
    found = 1'b0;
    prev_t = t24();
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (t24() == 0) begin
        found = 1'b1;
        chk("wrap_ca", int'(CA), 1);
        chk("wrap_prev", prev_t, 235959);
        break;
      end
      prev_t = t24();
    end
    chk("wrap_seen", int'(found), 1);
    step(1);
    chk("wrap_ca_1cyc", int'(CA), 0);
    chk("wrap_ca_cnt", ca_cnt - base, 1);

    // alarm at 00:02, displayed while targeting alarm
    set_mode(2'b01, 1'b1, 1'b0);
    press(0);
    press(0);
    chk("alm_disp", t24() / 100, 2);
    set_mode(2'b01, 1'b0, 1'b0);
    press(0);
    chk("alm_time", t24(), 100);
    set_mode(2'b00, 1'b0, 1'b1);
    found = 1'b0;
    early = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (t24() == 200) begin
        found = 1'b1;
        chk("alm_rise", int'(ALARM), 1);
        break;
      end
      if (ALARM) early++;
    end
    chk("alm_seen", int'(found), 1);
    chk("alm_early", early, 0);
    KEY[1] = 1'b0;
    step(3);
    chk("alm_dismiss", int'(ALARM), 0);
    KEY[1] = 1'b1;
    found = 1'b0;
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (ALARM) hi++;
      if (t24() == 300) begin
        found = 1'b1;
        break;
      end
    end
    chk("alm_stay_low", hi, 0);
    chk("alm_to_3m", int'(found), 1);

    // reset while KEY[0] is held in SET_MIN
    set_mode(2'b01, 1'b0, 1'b1);
    KEY[0] = 1'b0;
    step(1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk_reset("mid");
    step(6);
    KEY[0] = 1'b1;
    step(6);
    chk("mid_noinc", t24(), 0);
    SW[7] = 1'b1;
    step(3);
    chk("mid_alm_clr", t24() / 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
